// File: rtl/tree_acc_pkg.sv
// Shared definitions for the tree_sum_accumulator slice: state encoding
// and default widths used by the accumulator and its adder.
package tree_acc_pkg;

    localparam int DEF_IN_W  = 10;
    localparam int DEF_ACC_W = 11;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/tree_sum_accumulator_addsat.sv
// tree_acc_addsat: combinational acc + zero-extended sample.
// The carry out of ACC_W is always reported as ovf_s.
// Optional macro TREE_ACC_SATURATE_EN: an overflowing add clamps the sum
// to all-ones instead of wrapping.
module tree_acc_addsat #(
    parameter int IN_W  = 10,
    parameter int ACC_W = 11
) (
    input  logic [ACC_W-1:0] acc_s,
    input  logic [IN_W-1:0]  data_s,
    output logic [ACC_W-1:0] sum_s,
    output logic             ovf_s
);

    logic [ACC_W:0] raw_s;

    // Widened add so the carry out of ACC_W is visible, then wrap or clamp.
    always_comb begin
        raw_s = {1'b0, acc_s} + {{(ACC_W + 1 - IN_W){1'b0}}, data_s};
        ovf_s = raw_s[ACC_W];
`ifdef TREE_ACC_SATURATE_EN
        if (raw_s[ACC_W]) begin
            sum_s = {ACC_W{1'b1}};
        end else begin
            sum_s = raw_s[ACC_W-1:0];
        end
`else
        sum_s = raw_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/tree_sum_accumulator.sv
// tree_sum_accumulator: sums COUNT samples (or fewer on flush) from
// tree_adder_procedural and holds the total on a valid/ready output.
// Optional macro TREE_ACC_SATURATE_EN (in tree_acc_addsat): saturate
// instead of wrapping on accumulator overflow.
module tree_sum_accumulator
    import tree_acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int COUNT = 4,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;
    logic [ACC_W-1:0]   out_data_r;
    logic [CNT_W-1:0]   out_count_r;
    logic               out_ovf_r;

    logic               accept_s;
    logic               close_s;
    logic [ACC_W-1:0]   sum_s;
    logic               carry_s;
    logic [ACC_W-1:0]   new_acc_s;
    logic [CNT_W-1:0]   new_cnt_s;
    logic               new_ovf_s;

    tree_acc_addsat #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_addsat (
        .acc_s  (acc_r),
        .data_s (in_data),
        .sum_s  (sum_s),
        .ovf_s  (carry_s)
    );

    assign in_ready  = (state_r != ST_OUT);
    assign out_valid = (state_r == ST_OUT);
    assign out_data  = out_data_r;
    assign out_count = out_count_r;
    assign out_ovf   = out_ovf_r;

    // Post-accept accumulator view and the block close decision.
    always_comb begin
        accept_s = in_valid && in_ready;
        if (accept_s) begin
            new_acc_s = sum_s;
            new_cnt_s = cnt_r + CNT_W'(1);
            new_ovf_s = ovf_r | carry_s;
        end else begin
            new_acc_s = acc_r;
            new_cnt_s = cnt_r;
            new_ovf_s = ovf_r;
        end
        // A flush only closes a block that holds at least one sample.
        close_s = in_ready &&
                  ((accept_s && (new_cnt_s == CNT_W'(COUNT))) ||
                   (flush && ((cnt_r != {CNT_W{1'b0}}) || accept_s)));
    end

    // Block FSM: accumulate, capture the result on close, hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
            out_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ACCUM: begin
                    if (close_s) begin
                        out_data_r  <= new_acc_s;
                        out_count_r <= new_cnt_s;
                        out_ovf_r   <= new_ovf_s;
                        acc_r       <= {ACC_W{1'b0}};
                        cnt_r       <= {CNT_W{1'b0}};
                        ovf_r       <= 1'b0;
                        state_r     <= ST_OUT;
                    end else if (accept_s) begin
                        acc_r   <= new_acc_s;
                        cnt_r   <= new_cnt_s;
                        ovf_r   <= new_ovf_s;
                        state_r <= ST_ACCUM;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    acc_r   <= {ACC_W{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    ovf_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Directed bench for tree_sum_accumulator with a result scoreboard.
// Optional macro TREE_ACC_SATURATE_EN selects the saturating overflow result.
module tb_tree_sum_accumulator;

    typedef struct {
        logic [10:0] data;
        logic [3:0]  count;
        logic        ovf;
    } result_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [9:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic [3:0]  out_count;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;
    result_t exp_q[$];

    tree_sum_accumulator #(
        .IN_W  (10),
        .COUNT (4),
        .ACC_W (11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [10:0] d, input logic [3:0] c, input logic o);
        result_t r;
        r.data  = d;
        r.count = c;
        r.ovf   = o;
        exp_q.push_back(r);
    endtask

    // One sample, optionally with flush; inputs change 1 time unit after the edge.
    task automatic send(input logic [9:0] d, input logic f);
        in_valid = 1'b1;
        in_data  = d;
        flush    = f;
        chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Scoreboard: compare each taken result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                result_t r;
                r = exp_q.pop_front();
                chk("sb_out_data",  {21'd0, out_data},  {21'd0, r.data});
                chk("sb_out_count", {28'd0, out_count}, {28'd0, r.count});
                chk("sb_out_ovf",   {31'd0, out_ovf},   {31'd0, r.ovf});
            end
        end
    end

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 10'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {21'd0, out_data},  32'd0);
        chk("rst_out_count", {28'd0, out_count}, 32'd0);
        chk("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal block; result visible one cycle after the 4th accept.
        send(10'd259, 1'b0);
        send(10'd42,  1'b0);
        send(10'd176, 1'b0);
        chk("nom_no_early_valid", {31'd0, out_valid}, 32'd0);
        push(11'd576, 4'd4, 1'b0);
        send(10'd99, 1'b0);
        chk("nom_latency_valid", {31'd0, out_valid}, 32'd1);
        chk("nom_in_ready_low",  {31'd0, in_ready},  32'd0);
        @(posedge clk);
        #1;
        chk("nom_back_idle", {31'd0, out_valid}, 32'd0);
        chk("nom_data_kept", {21'd0, out_data},  32'd576);

        // Overflow block.
`ifdef TREE_ACC_SATURATE_EN
        push(11'd2047, 4'd4, 1'b1);
`else
        push(11'd112, 4'd4, 1'b1);
`endif
        for (int i = 0; i < 4; i++) send(10'd540, 1'b0);
        @(posedge clk);
        #1;

        // Flush after two samples.
        send(10'd259, 1'b0);
        send(10'd42,  1'b0);
        push(11'd301, 4'd2, 1'b0);
        flush_only();
        chk("flush_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Flush while idle with no sample produces nothing.
        flush_only();
        chk("idle_flush_no_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("idle_flush_no_valid2", {31'd0, out_valid}, 32'd0);

        // Flush together with an accept includes that sample.
        send(10'd259, 1'b0);
        send(10'd42,  1'b0);
        push(11'd477, 4'd3, 1'b0);
        send(10'd176, 1'b1);
        chk("flush_acc_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: result held, input stalled.
        out_ready = 1'b0;
        send(10'd259, 1'b0);
        send(10'd42,  1'b0);
        send(10'd176, 1'b0);
        push(11'd576, 4'd4, 1'b0);
        send(10'd99, 1'b0);
        in_valid = 1'b1;
        in_data  = 10'd7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    {31'd0, out_valid}, 32'd1);
            chk("bp_data",     {21'd0, out_data},  32'd576);
            chk("bp_count",    {28'd0, out_count}, 32'd4);
            chk("bp_in_ready", {31'd0, in_ready},  32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_released", {31'd0, out_valid}, 32'd0);
        push(11'd10, 4'd4, 1'b0);
        for (int i = 1; i <= 4; i++) send(10'(i), 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-block discards the partial sum.
        send(10'd10, 1'b0);
        send(10'd10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_data",  {21'd0, out_data},  32'd0);
        chk("arst_out_count", {28'd0, out_count}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(11'd40, 4'd4, 1'b0);
        for (int i = 0; i < 4; i++) send(10'd10, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
